// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile
//   I2C target with a small internal register file, running entirely on CLK.
//   SCL/SDA are synchronised, glitch filtered and edge detected. The target
//   decodes START, repeated START and STOP. It accepts a register index, then
//   takes burst writes or gives burst reads. The index auto-increments and
//   wraps to 0 after the last register.
//
// Ports
//   CLK      system clock (at least 16x the SCL rate)
//   RST_N    asynchronous reset, active low
//   SCL_IN   SCL pad input (asynchronous)
//   SDA_IN   SDA pad input (asynchronous)
//   SDA_OE   1 = pull SDA low, 0 = release (open-drain pad control)
//   REG_OUT  flat register file, register k occupies [8k+7:8k]
//   WR_STB   one-CLK pulse for each register written by the master
//   WR_IDX   index of the register written, valid with WR_STB
//   BUSY     high from own-address match until STOP or a NACK exit
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR   = 7'h27,
  parameter int         NUM_REGS   = 4,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] RST_VAL    = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SCL_IN,
  input  logic                  SDA_IN,
  output logic                  SDA_OE,
  output logic [NUM_REGS*8-1:0] REG_OUT,
  output logic                  WR_STB,
  output logic [7:0]            WR_IDX,
  output logic                  BUSY
);

  localparam int         CW         = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int         IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [7:0] LAST_IDX   = 8'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, IDX, IDX_ACK, WR, WR_ACK, RD, RD_ACK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: line 0 = SCL, line 1 = SDA.
  // A new level is accepted only after FILTER_LEN consecutive synchronised
  // samples disagree with the current filtered level. The total latency is
  // therefore 2 + FILTER_LEN clocks.
  // ---------------------------------------------------------------------------
  logic [1:0] pad_in;
  logic [1:0] filt_bus;
  logic [1:0] prev_bus;

  assign pad_in = {SDA_IN, SCL_IN};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cond
      logic          sync1_q, sync2_q, filt_q, prev_q;
      logic          filt_d;
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
          if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Both lines idle high, so the reset level avoids spurious edges.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          filt_q  <= 1'b1;
          prev_q  <= 1'b1;
          cnt_q   <= '0;
        end else begin
          sync1_q <= pad_in[gi];
          sync2_q <= sync1_q;
          filt_q  <= filt_d;
          prev_q  <= filt_q;
          cnt_q   <= cnt_d;
        end
      end

      assign filt_bus[gi] = filt_q;
      assign prev_bus[gi] = prev_q;
    end
  endgenerate

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl_f      = filt_bus[0];
  assign sda_f      = filt_bus[1];
  assign scl_p      = prev_bus[0];
  assign sda_p      = prev_bus[1];
  assign scl_rise   = scl_f & ~scl_p;
  assign scl_fall   = ~scl_f & scl_p;
  assign start_cond = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_cond  = scl_f & scl_p & ~sda_p & sda_f;

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] index_q, index_d;
  logic       ack_phase_q, ack_phase_d;  // 0: ACK slot not yet opened
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;            // IDX_ACK: index rejected; RD_ACK: master bit
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_stb_q, wr_stb_d;
  logic [7:0] wr_idx_q, wr_idx_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic [7:0] rx_byte;
  logic [7:0] next_idx;
  logic [7:0] rd_cur;
  logic [7:0] rd_next;

  assign rx_byte  = {shift_q[6:0], sda_f};
  assign next_idx = (index_q == LAST_IDX) ? 8'd0 : index_q + 8'd1;
  assign rd_cur   = regs_q[index_q[IW-1:0]];
  assign rd_next  = regs_q[next_idx[IW-1:0]];

  // Each ACK state sees two SCL falls. The first one ends the 8th bit and
  // opens the ACK slot. The second one ends the 9th clock and moves on.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    index_d     = index_q;
    ack_phase_d = ack_phase_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_stb_d    = 1'b0;
    wr_idx_d    = wr_idx_q;
    regs_d      = regs_q;

    if (stop_cond) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_cond) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d     = ADDR_ACK;
                busy_d      = 1'b1;
                rw_d        = rx_byte[0];
                ack_phase_d = 1'b0;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else if (rw_q) begin
              // Read: the first data bit replaces the ACK on this same fall.
              state_d   = RD;
              shift_d   = rd_cur;
              sda_oe_d  = ~rd_cur[7];
              bit_cnt_d = 3'd0;
            end else begin
              state_d   = IDX;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
            end
          end
        end

        IDX: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d     = IDX_ACK;
              ack_phase_d = 1'b0;
              if ({1'b0, rx_byte} >= NUM_REGS_W) begin
                nack_d = 1'b1;
              end else begin
                nack_d  = 1'b0;
                index_d = rx_byte;
              end
            end
          end
        end

        IDX_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = ~nack_q;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (nack_q) begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end else begin
                state_d   = WR;
                bit_cnt_d = 3'd0;
              end
            end
          end
        end

        WR: begin
          // The register is committed only when the 8th bit arrives. A byte
          // that is cut short by START or STOP therefore leaves no trace.
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              regs_d[index_q[IW-1:0]] = rx_byte;
              wr_stb_d    = 1'b1;
              wr_idx_d    = index_q;
              state_d     = WR_ACK;
              ack_phase_d = 1'b0;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              index_d   = next_idx;
              state_d   = WR;
              bit_cnt_d = 3'd0;
            end
          end
        end

        RD: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d  = ~shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            nack_d = sda_f;
          end else if (scl_fall) begin
            if (nack_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              index_d   = next_idx;
              shift_d   = rd_next;
              sda_oe_d  = ~rd_next[7];
              bit_cnt_d = 3'd0;
              state_d   = RD;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      index_q     <= 8'd0;
      ack_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_idx_q    <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RST_VAL;
      end
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      index_q     <= index_d;
      ack_phase_q <= ack_phase_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_stb_q    <= wr_stb_d;
      wr_idx_q    <= wr_idx_d;
      regs_q      <= regs_d;
    end
  end

  assign SDA_OE = sda_oe_q;
  assign WR_STB = wr_stb_q;
  assign WR_IDX = wr_idx_q;
  assign BUSY   = busy_q;

  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regout
      assign REG_OUT[8*gi +: 8] = regs_q[gi];
    end
  endgenerate

endmodule
